// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between an echo path (req0)
// and a status path (req1), with an optional inter-byte gap and a done watchdog.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 217,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req0_dv,
    input  logic [7:0] i_req0_byte,
    output logic       o_req0_ack,
    input  logic       i_req1_dv,
    input  logic [7:0] i_req1_byte,
    output logic       o_req1_ack,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam int CNT_MAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          rr1_q;      // 1: requester 1 wins a tie next time
    logic          tx_dv_q, ack0_q, ack1_q, timeout_q;
    logic [7:0]    tx_byte_q;
    logic [1:0]    grant_q;

    logic          pick1_d;
    logic          launch_d;

    assign pick1_d  = i_req1_dv & (~i_req0_dv | rr1_q);
    assign launch_d = (state_q == IDLE) & (i_req0_dv | i_req1_dv) & ~i_tx_active;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr1_q     <= 1'b0;
            tx_dv_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            timeout_q <= 1'b0;
            tx_byte_q <= 8'h00;
            grant_q   <= 2'b00;
        end else begin
            tx_dv_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (launch_d) begin
                        tx_byte_q <= pick1_d ? i_req1_byte : i_req0_byte;
                        tx_dv_q   <= 1'b1;
                        ack0_q    <= ~pick1_d;
                        ack1_q    <= pick1_d;
                        grant_q   <= pick1_d ? 2'b10 : 2'b01;
                        rr1_q     <= ~pick1_d;
                        cnt_q     <= '0;
                        state_q   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // done wins over a coincident terminal count
                    if (i_tx_done || cnt_q == TO_LAST) begin
                        if (!i_tx_done) timeout_q <= 1'b1;
                        cnt_q   <= '0;
                        grant_q <= 2'b00;
                        state_q <= (GAP_CLKS > 0) ? GAP : IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_tx_dv    = tx_dv_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_req0_ack = ack0_q;
    assign o_req1_ack = ack1_q;
    assign o_grant    = grant_q;
    assign o_busy     = (state_q != IDLE);
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance 0 has no gap, instance 1 has a 5-clock gap;
// both use a 20-clock done timeout and a small transmitter model (done 10 clocks after launch).
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] g;
    } exp_t;

    typedef struct {
        logic       r0v;
        logic [7:0] r0b;
        logic       r1v;
        logic [7:0] r1b;
        logic [7:0] eb;
        logic [1:0] eg;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_dv [2], r1_dv [2], r0_ack [2], r1_ack [2];
    logic       tx_dv [2], tx_active [2], tx_done [2], busy [2], tmo [2];
    logic       hang [2], force_act [2], m_act [2];
    logic [7:0] r0_byte [2], r1_byte [2], tx_byte [2];
    logic [1:0] grant [2];
    logic [3:0] m_cnt [2];

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t e0, e1;
    vec_t vt [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign tx_active[g] = m_act[g] | force_act[g];
        uart_tx_arbiter #(.GAP_CLKS(g == 0 ? 0 : 5), .TIMEOUT_CLKS(20)) u_dut (
            .i_clk(clk), .i_rst(rst_n),
            .i_req0_dv(r0_dv[g]), .i_req0_byte(r0_byte[g]), .o_req0_ack(r0_ack[g]),
            .i_req1_dv(r1_dv[g]), .i_req1_byte(r1_byte[g]), .o_req1_ack(r1_ack[g]),
            .o_tx_dv(tx_dv[g]), .o_tx_byte(tx_byte[g]),
            .i_tx_active(tx_active[g]), .i_tx_done(tx_done[g]),
            .o_grant(grant[g]), .o_busy(busy[g]), .o_timeout(tmo[g])
        );
    end

    // Transmitter model: busy for 10 clocks after a launch, then a done pulse.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i]   <= 1'b0;
                m_cnt[i]   <= 4'd0;
                tx_done[i] <= 1'b0;
            end else begin
                tx_done[i] <= 1'b0;
                if (tx_dv[i] && !hang[i]) begin
                    m_act[i] <= 1'b1;
                    m_cnt[i] <= 4'd10;
                end else if (m_act[i]) begin
                    if (m_cnt[i] == 4'd1) begin
                        tx_done[i] <= 1'b1;
                        m_act[i]   <= 1'b0;
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 4'd1;
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input logic [7:0] b, input logic [1:0] g);
        exp_t e;
        e.b = b;
        e.g = g;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: every launch must match the oldest expected byte/owner.
    always @(negedge clk) begin
        if (rst_n && tx_dv[0]) begin
            if (sb0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL sb0_unexpected: launch of 0x%0h, none expected", tx_byte[0]);
            end else begin
                e0 = sb0.pop_front();
                cmp("sb0_byte", 32'(tx_byte[0]), 32'(e0.b));
                cmp("sb0_grant", 32'(grant[0]), 32'(e0.g));
                cmp("sb0_ack", 32'({r1_ack[0], r0_ack[0]}), 32'(e0.g));
            end
        end
        if (rst_n && tx_dv[1]) begin
            if (sb1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL sb1_unexpected: launch of 0x%0h, none expected", tx_byte[1]);
            end else begin
                e1 = sb1.pop_front();
                cmp("sb1_byte", 32'(tx_byte[1]), 32'(e1.b));
                cmp("sb1_grant", 32'(grant[1]), 32'(e1.g));
                cmp("sb1_ack", 32'({r1_ack[1], r0_ack[1]}), 32'(e1.g));
            end
        end
    end

    task automatic wait_idle(input int i);
        int k = 0;
        while (busy[i] && k < 100) begin
            @(negedge clk);
            k++;
        end
        cmp("return_to_idle", 32'(busy[i]), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  c0, c1, k;
        logic bad;

        vt[0] = '{1'b1, 8'h41, 1'b0, 8'h00, 8'h41, 2'b01};
        vt[1] = '{1'b0, 8'h00, 1'b1, 8'h55, 8'h55, 2'b10};
        vt[2] = '{1'b1, 8'hA0, 1'b1, 8'hB0, 8'hA0, 2'b01};
        vt[3] = '{1'b1, 8'hA1, 1'b1, 8'hB1, 8'hB1, 2'b10};
        vt[4] = '{1'b0, 8'h00, 1'b1, 8'h77, 8'h77, 2'b10};
        vt[5] = '{1'b1, 8'hC0, 1'b1, 8'hC1, 8'hC0, 2'b01};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r0_dv[i] = 0; r1_dv[i] = 0; r0_byte[i] = 0; r1_byte[i] = 0;
            hang[i] = 0; force_act[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            cmp("reset_outputs", 32'({tx_byte[i], grant[i], busy[i], tmo[i], tx_dv[i],
                                      r0_ack[i], r1_ack[i]}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("idle_after_reset", 32'({busy[0], tx_dv[0], busy[1], tx_dv[1]}), 32'd0);

        // Both held valid: strict alternation starting with requester 0.
        r0_byte[0] = 8'h30; r1_byte[0] = 8'h31; r0_dv[0] = 1; r1_dv[0] = 1;
        for (int j = 0; j < 4; j++) begin
            sb0.push_back(mk(8'h30, 2'b01));
            sb0.push_back(mk(8'h31, 2'b10));
        end
        c0 = 4; c1 = 4; k = 0;
        while ((c0 > 0 || c1 > 0) && k < 400) begin
            @(negedge clk);
            k++;
            if (r0_ack[0]) begin c0--; if (c0 == 0) r0_dv[0] = 0; end
            if (r1_ack[0]) begin c1--; if (c1 == 0) r1_dv[0] = 0; end
        end
        r0_dv[0] = 0; r1_dv[0] = 0;
        cmp("alternate_acks_left", 32'(c0 + c1), 32'd0);
        wait_idle(0);

        // Single-byte vectors, including round-robin tie breaks.
        foreach (vt[v]) begin
            r0_dv[0] = vt[v].r0v; r0_byte[0] = vt[v].r0b;
            r1_dv[0] = vt[v].r1v; r1_byte[0] = vt[v].r1b;
            sb0.push_back(mk(vt[v].eb, vt[v].eg));
            @(negedge clk);
            cmp("launch_latency", 32'(tx_dv[0]), 32'd1);
            r0_dv[0] = 0; r1_dv[0] = 0;
            @(negedge clk);
            cmp("strobe_width", 32'({tx_dv[0], r0_ack[0], r1_ack[0]}), 32'd0);
            cmp("byte_held", 32'(tx_byte[0]), 32'(vt[v].eb));
            wait_idle(0);
        end
        cmp("no_timeout_yet", 32'(tmo[0]), 32'd0);

        // Stalled transmitter: timeout 20 edges after launch, pending byte still goes.
        hang[0] = 1;
        r0_dv[0] = 1; r0_byte[0] = 8'h5A;
        sb0.push_back(mk(8'h5A, 2'b01));
        @(negedge clk);
        cmp("stall_launch", 32'(tx_dv[0]), 32'd1);
        r0_dv[0] = 0; r1_dv[0] = 1; r1_byte[0] = 8'h6B;
        sb0.push_back(mk(8'h6B, 2'b10));
        k = 0;
        while (!tmo[0] && k < 40) begin
            @(negedge clk);
            k++;
        end
        cmp("timeout_edges", 32'(k), 32'd20);
        hang[0] = 0;
        @(negedge clk);
        cmp("launch_after_timeout", 32'(tx_dv[0]), 32'd1);
        r1_dv[0] = 0;
        wait_idle(0);
        cmp("timeout_sticky", 32'(tmo[0]), 32'd1);

        // Transmitter busy in IDLE holds off the launch.
        force_act[0] = 1;
        r1_dv[0] = 1; r1_byte[0] = 8'h99;
        sb0.push_back(mk(8'h99, 2'b10));
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_dv[0] || r1_ack[0]) bad = 1;
        end
        cmp("held_off_while_active", 32'(bad), 32'd0);
        force_act[0] = 0;
        @(negedge clk);
        cmp("launch_after_active_drop", 32'(tx_dv[0]), 32'd1);
        r1_dv[0] = 0;
        wait_idle(0);

        // Gap instance: next launch GAP_CLKS+1 = 6 edges after the edge sampling done.
        r0_dv[1] = 1; r0_byte[1] = 8'h11; r1_dv[1] = 1; r1_byte[1] = 8'h22;
        sb1.push_back(mk(8'h11, 2'b01));
        sb1.push_back(mk(8'h22, 2'b10));
        k = 0;
        while (!r0_ack[1] && k < 20) begin @(negedge clk); k++; end
        cmp("gap_first_ack", 32'(r0_ack[1]), 32'd1);
        r0_dv[1] = 0;
        k = 0;
        while (!tx_done[1] && k < 40) begin @(negedge clk); k++; end
        cmp("gap_done_seen", 32'(tx_done[1]), 32'd1);
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (tx_dv[1]) break;
        end
        cmp("gap_launch_edges", 32'(k - 1), 32'd6);
        r1_dv[1] = 0;
        wait_idle(1);

        // Reset while waiting for done clears everything at once.
        r0_dv[0] = 1; r0_byte[0] = 8'h33;
        sb0.push_back(mk(8'h33, 2'b01));
        @(negedge clk);
        r0_dv[0] = 0;
        repeat (3) @(negedge clk);
        cmp("busy_before_reset", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("async_reset_byte", 32'(tx_byte[0]), 32'd0);
        cmp("async_reset_flags", 32'({grant[0], busy[0], tmo[0], tx_dv[0], r0_ack[0], r1_ack[0]}),
            32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r0_dv[0] = 1; r0_byte[0] = 8'h44; r1_dv[0] = 1; r1_byte[0] = 8'h45;
        sb0.push_back(mk(8'h44, 2'b01));
        @(negedge clk);
        cmp("req0_first_after_reset", 32'({r1_ack[0], r0_ack[0]}), 32'd1);
        r0_dv[0] = 0; r1_dv[0] = 0;
        wait_idle(0);

        cmp("sb0_drained", 32'(sb0.size()), 32'd0);
        cmp("sb1_drained", 32'(sb1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between two byte requesters: the loopback echo path (requester 0) and a status/report path (requester 1). It accepts one byte at a time from each requester over a level-valid/pulse-ack handshake, launches it into the transmitter with a single-cycle data-valid strobe, and waits for the transmitter's done pulse before serving the next byte. An optional inter-byte gap and a done-timeout watchdog make it robust against a stalled transmitter.

## Interface
- CLKS_PER_BIT, 217 — bit period of the attached transmitter; used only to size the default timeout.
- GAP_CLKS, 0 — idle clocks inserted after each byte's done before the next launch (0 = back-to-back).
- TIMEOUT_CLKS, 12*CLKS_PER_BIT — max clocks to wait for transmitter done after a launch.

- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_req0_dv  in  1  requester 0 has a byte; held high, byte stable, until ack.
- i_req0_byte  in  8  requester 0 data.
- o_req0_ack  out  1  one-cycle pulse: requester 0 byte captured.
- i_req1_dv  in  1  requester 1 valid (same rules).
- i_req1_byte  in  8  requester 1 data.
- o_req1_ack  out  1  one-cycle pulse: requester 1 byte captured.
- o_tx_dv  out  1  one-cycle launch strobe to transmitter.
- o_tx_byte  out  8  byte to transmitter; stable from launch until next launch.
- i_tx_active  in  1  transmitter busy.
- i_tx_done  in  1  transmitter one-cycle completion pulse.
- o_grant  out  2  one-hot owner of current byte (00 when idle).
- o_busy  out  1  high in any state other than IDLE.
- o_timeout  out  1  sticky: a done-timeout occurred; cleared only by reset.

## Operation
- States: IDLE, WAIT_DONE, GAP.
- Reset (i_rst low, async): state IDLE; o_tx_dv, o_req0_ack, o_req1_ack, o_busy, o_timeout = 0; o_tx_byte = 8'h00; o_grant = 2'b00; counter = 0; RR pointer favours requester 0.
- IDLE: launch when (i_req0_dv | i_req1_dv) and i_tx_active low. Winner: if only one valid, that one; if both, the one the RR pointer favours. On launch (registered): o_tx_byte <= winner byte, o_tx_dv <= 1, winner ack <= 1, o_grant <= winner one-hot, RR pointer <= the other requester, counter <= 0, state <= WAIT_DONE.
- o_tx_dv and acks deassert the following cycle (exactly one cycle wide).
- WAIT_DONE: counter increments each cycle. On i_tx_done: counter <= 0, o_grant <= 00, state <= GAP if GAP_CLKS>0 else IDLE. If counter reaches TIMEOUT_CLKS-1 without done: o_timeout <= 1, same exit as done. i_tx_done in the same cycle as timeout terminal count: treated as done, no timeout flag.
- GAP: counts GAP_CLKS cycles, then IDLE. Requests arriving during WAIT_DONE/GAP wait (no ack).
- i_tx_done seen in IDLE or GAP: ignored.
- Requester dropping dv before ack: request withdrawn, no byte sent. Byte changes while dv held: value sampled at launch cycle is sent.
- Counter width: $clog2 of max(TIMEOUT_CLKS, GAP_CLKS)+1; no wrap.

## Timing
- Request valid at edge n (idle, transmitter inactive) -> o_tx_dv, ack, o_grant high after edge n+1, i.e. 1-cycle latency.
- Earliest next launch: cycle after i_tx_done when GAP_CLKS=0; GAP_CLKS+1 cycles after done otherwise.
- One byte in flight at most; no launch while i_tx_active high.
- Reset mid-WAIT_DONE: outputs return to reset values immediately; in-flight byte is abandoned (transmitter owns its own reset).

## Test plan
- Single req0 byte 8'h41, model transmitter with done after 10 clocks -> one o_tx_dv pulse with o_tx_byte=8'h41, o_req0_ack pulse same cycle, o_grant=01, back to IDLE after done.
- Both requesters held valid with 8'h30 (req0) and 8'h31 (req1), 4 bytes each -> launches alternate 30,31,30,31,...; first after reset is req0.
- GAP_CLKS=5: two queued bytes -> second o_tx_dv exactly 6 cycles after first i_tx_done.
- Transmitter never pulses done, TIMEOUT_CLKS=20 -> o_timeout rises 20 cycles after launch, stays high, next pending byte still launched.
- i_tx_active held high in IDLE with req1 valid -> no launch/ack until active drops; launch 1 cycle later.
- Assert i_rst low during WAIT_DONE -> all outputs zero asynchronously; after release, req0 served first.
